// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and a variable-latency RAM.
// The master drives the request; the slave answers with mem_ready/mem_rdata.
interface load_store_unit_if #(
  parameter int ADDR_W = 8
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_be,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_be,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RISC-V load/store unit: converts lb/lh/lw/lbu/lhu/sb/sh/sw
// into word-aligned byte-enabled accesses and stalls the core meanwhile.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_store,
  input  logic [2:0]          f3,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdat,
  output logic                stall,
  output logic                ld_valid,
  output logic [31:0]         ld_data,
  output logic                fault,
  load_store_unit_if.master   mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t nxt;

  logic              is_half;
  logic              is_word;
  logic              f3_ok;
  logic              misal;
  logic              bad;
  logic              accept;
  logic              done;
  logic [3:0]        be_c;
  logic [31:0]       wd_c;
  logic [31:0]       shifted;
  logic [31:0]       ext;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              mwe_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [31:0]       mwdata_q;
  logic [3:0]        mbe_q;
  logic [31:0]       ld_q;

  logic              unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  assign is_half = (f3[1:0] == 2'b01);
  assign is_word = (f3[1:0] == 2'b10);

  always_comb begin
    f3_ok = 1'b0;
    if (req_store)
      f3_ok = (f3 == 3'b000) || (f3 == 3'b001)
           || (f3 == 3'b010);
    else
      f3_ok = (f3 != 3'b011) && (f3 != 3'b110)
           && (f3 != 3'b111);
  end

  assign misal  = (is_half & addr[0])
                | (is_word & (|addr[1:0]));
  assign bad    = ~f3_ok | misal;
  assign accept = (state == IDLE) & req_valid & ~bad;
  assign done   = (state == BUSY) & mem.mem_ready;

  always_comb begin
    be_c = 4'b0001 << addr[1:0];
    wd_c = {4{wdat[7:0]}};
    unique case (1'b1)
      is_word: begin
        be_c = 4'b1111;
        wd_c = wdat;
      end
      is_half: begin
        be_c = 4'b0011 << addr[1:0];
        wd_c = {2{wdat[15:0]}};
      end
      default: ;
    endcase
  end

  assign shifted = mem.mem_rdata >> {off_q, 3'b000};

  always_comb begin
    ext = shifted;
    unique case (1'b1)
      (f3_q == 3'b000):
        ext = {{24{shifted[7]}}, shifted[7:0]};
      (f3_q == 3'b001):
        ext = {{16{shifted[15]}}, shifted[15:0]};
      (f3_q == 3'b100):
        ext = {24'd0, shifted[7:0]};
      (f3_q == 3'b101):
        ext = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (accept) nxt = BUSY;
      BUSY:    if (mem.mem_ready) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    stall       = 1'b0;
    fault       = 1'b0;
    ld_valid    = 1'b0;
    mem.mem_req = 1'b0;
    unique case (state)
      IDLE: begin
        stall = req_valid & ~bad;
        fault = req_valid & bad;
      end
      BUSY: begin
        stall       = 1'b1;
        mem.mem_req = 1'b1;
      end
      RESP:    ld_valid = ~we_q;
      default: ;
    endcase
  end

  // Bus registers are zeroed as soon as the access completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= 32'd0;
      mbe_q    <= 4'd0;
      ld_q     <= 32'd0;
    end else if (accept) begin
      we_q     <= req_store;
      f3_q     <= f3;
      off_q    <= addr[1:0];
      mwe_q    <= req_store;
      maddr_q  <= {addr[ADDR_W-1:2], 2'b00};
      mwdata_q <= wd_c;
      mbe_q    <= be_c;
    end else if (done) begin
      mwe_q    <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= 32'd0;
      mbe_q    <= 4'd0;
      if (!we_q)
        ld_q <= ext;
    end
  end

  assign mem.mem_we    = mwe_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = mwdata_q;
  assign mem.mem_be    = mbe_q;
  assign ld_data       = ld_q;

endmodule
